flash_ctrl: RTL and testbench
=============================

Name: flash_ctrl

Overview:
- Initiator side of the parallel NOR flash interface; the flash device model is the responder it talks to.
- Accepts single 32-bit read requests from the CPU memory stage and runs two timed 16-bit flash read cycles (word mode, byte_n high).
- Undoes the per-halfword byte swap on the flash data bus and returns the assembled word with a one-cycle ack.
- Optional block-program path for writing halfwords to flash.

Parameters:
- WAIT_CYCLES, 8, cycles oe_n is held low before flash_data is sampled; range 1..255.
- GAP_CYCLES, 2, cycles ce_n/oe_n are held high between the two halfword accesses; range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  request strobe; sampled only in IDLE.
- we_i  in  1  1 = program request; meaningful only with FLASH_PROGRAM_EN, otherwise ignored.
- addr_i  in  23  byte address; bits [1:0] ignored.
- wdata_i  in  16  halfword to program (FLASH_PROGRAM_EN only).
- rdata_o  out  32  assembled read word.
- ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high from request accept until ack.
- flash_a  out  23  flash address; [0] always 0.
- flash_ce_n  out  1  chip enable.
- flash_oe_n  out  1  output enable.
- flash_we_n  out  1  write enable.
- flash_rp_n  out  1  reset/powerdown; constant 1 after reset.
- flash_byte_n  out  1  constant 1 (16-bit mode).
- flash_data  inout  16  driven only during write pulses, else high-Z.

Behaviour:
- Reset values:
  - rdata_o = 0, ack_o = 0, busy_o = 0.
  - flash_ce_n = flash_oe_n = flash_we_n = 1, flash_a = 0, flash_data = Z.
  - flash_rp_n = 0 while rst_n is low, 1 afterwards.
- Reset mid-operation: abort immediately to IDLE. No ack is issued and all strobes go inactive asynchronously.
- Halfword address hw = addr_i[22:2]*2. flash_a = {hw, 1'b0} for the first access and {hw+1, 1'b0} for the second. Address bits are latched at accept.
- States:
  - IDLE: if req_i, latch the address, set busy_o and go to RD0.
  - RD0: ce_n = oe_n = 0 and flash_a = first address. The counter runs WAIT_CYCLES cycles. On the last cycle latch lo = {flash_data[7:0], flash_data[15:8]}, then go to GAP.
  - GAP: ce_n = oe_n = 1 for GAP_CYCLES cycles, then go to RD1.
  - RD1: same as RD0 at the second address. Latch hi the same way, then go to DONE.
  - DONE: rdata_o = {hi, lo}, ack_o = 1 for this cycle only, busy_o = 0, then go to IDLE.
- Read latency from the req_i cycle to the ack_o cycle is 2*WAIT_CYCLES + GAP_CYCLES + 2.
- rdata_o holds its value until the next read's DONE.
- req_i while busy_o = 1 is ignored; there is no queueing.
- req_i asserted in the same cycle as ack_o is ignored. The next accept happens at the earliest one cycle later, in IDLE.
- flash_we_n stays 1 in all read states.
- Address wrap: hw+1 at the top of the flash wraps to 0 (22-bit halfword arithmetic).

Optional Feature:
- Macro FLASH_PROGRAM_EN.
- When defined and req_i = 1 with we_i = 1 in IDLE, the program sequence runs on hw = addr_i[22:1]:
  - WR_CMD: drive 0x0040 with we_n low for WAIT_CYCLES cycles, then GAP.
  - WR_DAT: drive wdata_i (latched at accept) with we_n low for WAIT_CYCLES cycles, then GAP.
  - POLL: read cycles as in RD0, repeated with a GAP between them, until status bit 7 = 1.
  - DONE: ack_o pulses and rdata_o = {16'h0, status}.
- In all write states ce_n = 0 and oe_n = 1; flash_data is driven only while we_n = 0.
- When undefined, we_i is ignored (every request is a read), the write states are absent and flash_data is never driven.

Decomposition:
- Shared package flash_pkg holds:
  - state encoding localparams (IDLE, RD0, GAP, RD1, DONE, WR_CMD, WR_DAT, POLL);
  - FLASH_CMD_PROGRAM = 16'h0040;
  - STATUS_READY_BIT = 7.
- One natural sub-module, flash_timer: a loadable down-counter producing a terminal-count pulse. It is shared by the wait and gap phases.

Test Plan:
- Read, flash holds 0x1234 at hw 0x10 and 0xABCD at hw 0x11 (as seen on the bus after the model's swap); req addr_i = 0x000020 -> ack at cycle 20 with defaults, rdata_o = 0xCDAB3412 (byte-unswapped {hi, lo}).
- Timing: WAIT_CYCLES = 3, GAP_CYCLES = 1 -> ack exactly 9 cycles after req. flash_oe_n is low for two 3-cycle windows separated by 1 high cycle.
- Busy rejection: second req during RD1 with a different address -> exactly one ack, with data from the first address. req in the ack cycle -> ignored.
- Reset mid-read: deassert rst_n during RD0 -> strobes go to 1 immediately, no ack. After release, a new read completes normally.
- Top address: addr_i = 0x7FFFFC -> second access flash_a = 0x7FFFFE. addr_i = 0x7FFFFE -> same hw as 0x7FFFFC (bits [1:0] ignored).
- FLASH_PROGRAM_EN: write 0x5A5A at hw 0x40 -> bus shows 0x0040 then 0x5A5A with we_n low; POLL repeats until the status returns 0x0080; ack with rdata_o = 0x00000080.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the NOR flash controller: state encoding, program command and status bit.
package flash_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD0    = 3'd1,
      GAP    = 3'd2,
      RD1    = 3'd3,
      DONE   = 3'd4,
      WR_CMD = 3'd5,
      WR_DAT = 3'd6,
      POLL   = 3'd7
   } state_t;

   localparam logic [15:0] FLASH_CMD_PROGRAM = 16'h0040;
   localparam int          STATUS_READY_BIT  = 7;

   // The flash bus presents each halfword byte-swapped.
   function automatic logic [15:0] unswap(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module flash_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       tc
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 8'd0;
      else if (load)
         cnt <= load_val;
      else if (cnt != 8'd0)
         cnt <= cnt - 8'd1;
   end

   assign tc = (cnt == 8'd0);

endmodule

// File: rtl/flash_ctrl.sv
// 32-bit read bridge onto a 16-bit NOR flash: two timed halfword reads, byte-unswapped and assembled.
// Defining FLASH_PROGRAM_EN adds the halfword program sequence (command, data, status poll).
//
// state  | meaning
// IDLE   | waiting for req_i
// RD0    | first halfword read, oe_n low for WAIT_CYCLES
// GAP    | ce_n/oe_n high for GAP_CYCLES, then resume at gap_nxt_q
// RD1    | second halfword read at hw+1
// DONE   | one-cycle ack, rdata_o valid
// WR_CMD | program command on the bus with we_n low
// WR_DAT | program data on the bus with we_n low
// POLL   | status read until the ready bit is set
module flash_ctrl
   import flash_pkg::*;
#(
   parameter int WAIT_CYCLES = 8,
   parameter int GAP_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [22:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        busy_o,
   output logic [22:0] flash_a,
   output logic        flash_ce_n,
   output logic        flash_oe_n,
   output logic        flash_we_n,
   output logic        flash_rp_n,
   output logic        flash_byte_n,
   inout  wire  [15:0] flash_data
);

   localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES - 1);
   localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

   state_t      state, state_nxt, gap_nxt_q, gap_nxt_d;
   logic [21:0] hw_q;
   logic [15:0] lo_q;
   logic [31:0] rdata_q;
   logic        rp_q;
   logic        tmr_load, tmr_tc;
   logic [7:0]  tmr_val;
   logic [15:0] rd_hw;
   logic        is_wr;

   assign rd_hw = unswap(flash_data);

`ifdef FLASH_PROGRAM_EN
   logic [15:0] wdata_q, dout;
   logic        drive;
   assign is_wr      = we_i;
   assign flash_data = drive ? dout : 16'hzzzz;
`else
   logic unused_prog;
   assign is_wr       = 1'b0;
   assign unused_prog = &{1'b0, we_i, wdata_i};
   assign flash_data  = 16'hzzzz;
`endif

   flash_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gap_nxt_q <= RD1;
         hw_q      <= '0;
         lo_q      <= '0;
         rdata_q   <= '0;
         rp_q      <= 1'b0;
      end else begin
         state     <= state_nxt;
         gap_nxt_q <= gap_nxt_d;
         rp_q      <= 1'b1;
         if (state == IDLE && req_i)
            hw_q <= is_wr ? addr_i[22:1] : {addr_i[22:2], 1'b0};
         if (state == RD0 && tmr_tc)
            lo_q <= rd_hw;
         if (state == RD1 && tmr_tc)
            rdata_q <= {rd_hw, lo_q};
`ifdef FLASH_PROGRAM_EN
         if (state == POLL && tmr_tc && rd_hw[STATUS_READY_BIT])
            rdata_q <= {16'h0000, rd_hw};
`endif
      end
   end

`ifdef FLASH_PROGRAM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdata_q <= '0;
      else if (state == IDLE && req_i)
         wdata_q <= wdata_i;
   end
`endif

   always_comb begin
      state_nxt  = state;
      gap_nxt_d  = gap_nxt_q;
      tmr_load   = 1'b0;
      tmr_val    = WAIT_LD;
      flash_ce_n = 1'b1;
      flash_oe_n = 1'b1;
      flash_we_n = 1'b1;
      flash_a    = '0;
      ack_o      = 1'b0;
      busy_o     = 1'b1;
`ifdef FLASH_PROGRAM_EN
      drive      = 1'b0;
      dout       = '0;
`endif
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (req_i) begin
               tmr_load  = 1'b1;
               state_nxt = is_wr ? WR_CMD : RD0;
            end
         end
         RD0: begin
            flash_ce_n = 1'b0;
            flash_oe_n = 1'b0;
            flash_a    = {hw_q, 1'b0};
            if (tmr_tc) begin
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
               gap_nxt_d = RD1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (tmr_tc) begin
               tmr_load  = 1'b1;
               state_nxt = gap_nxt_q;
            end
         end
         RD1: begin
            flash_ce_n = 1'b0;
            flash_oe_n = 1'b0;
            flash_a    = {hw_q + 22'd1, 1'b0};
            if (tmr_tc)
               state_nxt = DONE;
         end
         DONE: begin
            ack_o     = 1'b1;
            busy_o    = 1'b0;
            state_nxt = IDLE;
         end
`ifdef FLASH_PROGRAM_EN
         WR_CMD: begin
            flash_ce_n = 1'b0;
            flash_we_n = 1'b0;
            drive      = 1'b1;
            dout       = FLASH_CMD_PROGRAM;
            flash_a    = {hw_q, 1'b0};
            if (tmr_tc) begin
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
               gap_nxt_d = WR_DAT;
               state_nxt = GAP;
            end
         end
         WR_DAT: begin
            flash_ce_n = 1'b0;
            flash_we_n = 1'b0;
            drive      = 1'b1;
            dout       = wdata_q;
            flash_a    = {hw_q, 1'b0};
            if (tmr_tc) begin
               tmr_load  = 1'b1;
               tmr_val   = GAP_LD;
               gap_nxt_d = POLL;
               state_nxt = GAP;
            end
         end
         POLL: begin
            flash_ce_n = 1'b0;
            flash_oe_n = 1'b0;
            flash_a    = {hw_q, 1'b0};
            if (tmr_tc) begin
               if (rd_hw[STATUS_READY_BIT]) begin
                  state_nxt = DONE;
               end else begin
                  tmr_load  = 1'b1;
                  tmr_val   = GAP_LD;
                  gap_nxt_d = POLL;
                  state_nxt = GAP;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   assign rdata_o      = rdata_q;
   assign flash_rp_n   = rp_q;
   assign flash_byte_n = 1'b1;

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboard bench for flash_ctrl: default-timing instance under random reads, fast instance for timing.
module tb_flash_ctrl;

   localparam int W0 = 8, G0 = 2;
   localparam int LAT0 = 2*W0 + G0 + 2;   // req cycle and ack cycle both counted
   localparam int W1 = 3, G1 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        we0 = 1'b0;
   logic [15:0] wdata0 = '0;

   logic        req0 = 1'b0;
   logic [22:0] addr0 = '0;
   logic [31:0] rdata0;
   logic        ack0, busy0, ce0, oe0, wen0, rp0, byte0;
   logic [22:0] fa0;
   wire  [15:0] fd0;

   logic        req1 = 1'b0;
   logic [22:0] addr1 = '0;
   logic [31:0] rdata1;
   logic        ack1, busy1, ce1, oe1, wen1, rp1, byte1;
   logic [22:0] fa1;
   wire  [15:0] fd1;

   typedef struct {
      logic [31:0] data;
      int          req_cyc;
   } exp_t;
   exp_t sb_q[$];

   int   n_cmp = 0, n_err = 0;
   int   free_cyc = 0;
   logic chk_pins = 1'b0;

   // Flash contents as seen on the bus (the device already swapped bytes).
   function automatic logic [15:0] bus_val(input logic [21:0] hw);
      if (hw == 22'h10) return 16'h1234;
      if (hw == 22'h11) return 16'hABCD;
      return hw[15:0] ^ {hw[21:16], hw[21:16], hw[3:0]} ^ 16'h5AC3;
   endfunction

   function automatic logic [15:0] swap16(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

   function automatic logic [31:0] exp_word(input logic [22:0] a);
      logic [21:0] hw;
      hw = {a[22:2], 1'b0};
      return {swap16(bus_val(hw + 22'd1)), swap16(bus_val(hw))};
   endfunction

   assign fd0 = (!ce0 && !oe0) ? bus_val(fa0[22:1]) : 16'hzzzz;
   assign fd1 = (!ce1 && !oe1) ? bus_val(fa1[22:1]) : 16'hzzzz;

   flash_ctrl #(.WAIT_CYCLES(W0), .GAP_CYCLES(G0)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
      .rdata_o(rdata0), .ack_o(ack0), .busy_o(busy0), .flash_a(fa0), .flash_ce_n(ce0),
      .flash_oe_n(oe0), .flash_we_n(wen0), .flash_rp_n(rp0), .flash_byte_n(byte0),
      .flash_data(fd0)
   );

   flash_ctrl #(.WAIT_CYCLES(W1), .GAP_CYCLES(G1)) u_fast (
      .clk(clk), .rst_n(rst_n), .req_i(req1), .we_i(we0), .addr_i(addr1), .wdata_i(wdata0),
      .rdata_o(rdata1), .ack_o(ack1), .busy_o(busy1), .flash_a(fa1), .flash_ce_n(ce1),
      .flash_oe_n(oe1), .flash_we_n(wen1), .flash_rp_n(rp1), .flash_byte_n(byte1),
      .flash_data(fd1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && ack0) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ack: rdata %h with nothing outstanding (cycle %0d)", rdata0, cyc);
         end else begin
            e = sb_q.pop_front();
            check("rdata", rdata0, e.data);
            check("latency", 32'(cyc - e.req_cyc + 1), 32'(LAT0));
            check("busy_at_ack", 32'(busy0), 32'd0);
         end
      end
      if (chk_pins)
         check("static_pins", 32'({wen0, byte0, rp0, wen1, byte1, rp1}), 32'h3F);
   end

   // One cycle of stimulus on the default instance; the model decides acceptance.
   task automatic cycle_req(input logic r, input logic [22:0] a);
      exp_t e;
      @(posedge clk);
      #1;
      req0  = r;
      addr0 = a;
      if (r && cyc >= free_cyc) begin
         e.data    = exp_word(a);
         e.req_cyc = cyc;
         sb_q.push_back(e);
         free_cyc  = cyc + LAT0;
      end
   endtask

   task automatic drain();
      repeat (LAT0 + 2) cycle_req(1'b0, 23'($urandom));
      check("drain_outstanding", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   initial begin
      logic [22:0] ta [2];
      logic [19:0] oe_pat, ack_pat;
      logic [31:0] d8, d17;
      int          rc;

      #2;
      check("rst_rdata", rdata0, 32'd0);
      check("rst_ack_busy", 32'({ack0, busy0, ack1, busy1}), 32'd0);
      check("rst_strobes", 32'({ce0, oe0, wen0, ce1, oe1, wen1}), 32'h3F);
      check("rst_addr", 32'(fa0), 32'd0);
      check("rst_rp_byte", 32'({rp0, byte0}), 32'h1);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_pins = 1'b1;

      cycle_req(1'b1, 23'h000020);
      drain();

      // req during the ack cycle is dropped; the following cycle is accepted
      cycle_req(1'b1, 23'h000040);
      repeat (LAT0 - 2) cycle_req(1'b0, 23'h000040);
      cycle_req(1'b1, 23'h001000);
      cycle_req(1'b1, 23'h002000);
      drain();

      ta[0] = 23'h7FFFFC;
      ta[1] = 23'h7FFFFE;
      for (int t = 0; t < 2; t++) begin
         cycle_req(1'b1, ta[t]);
         rc = cyc;
         cycle_req(1'b0, ta[t]);
         @(negedge clk);
         check("top_first_addr", 32'(fa0), 32'h7FFFFC);
         while (cyc < rc + W0 + G0 + 1) @(negedge clk);
         check("top_second_addr", 32'(fa0), 32'h7FFFFE);
         drain();
      end

      // fast instance: oe_n windows, busy rejection, ack-cycle rejection, re-accept
      oe_pat  = '0;
      ack_pat = '0;
      d8      = '0;
      d17     = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         req1  = (k == 0 || k == 5 || k == 8 || k == 9);
         addr1 = (k == 5) ? 23'h40 : (k == 8) ? 23'h1000 : (k == 9) ? 23'h60 : 23'h20;
         @(negedge clk);
         oe_pat[k]  = oe1;
         ack_pat[k] = ack1;
         if (k == 8)  d8  = rdata1;
         if (k == 17) d17 = rdata1;
      end
      @(posedge clk);
      #1 req1 = 1'b0;
      check("fast_oe_windows", 32'(oe_pat), 32'h000E2311);
      check("fast_ack_cycles", 32'(ack_pat), 32'h00020100);
      check("fast_rdata_first", d8, 32'hCDAB3412);
      check("fast_rdata_second", d17, exp_word(23'h60));

      for (int i = 0; i < 1500; i++)
         cycle_req($urandom_range(0, 3) == 0, 23'($urandom));
      cycle_req(1'b0, 23'h0);
      drain();

      // reset in the middle of RD0
      cycle_req(1'b1, 23'h000300);
      repeat (3) cycle_req(1'b0, 23'h000300);
      check("pre_reset_oe", 32'(oe0), 32'd0);
      chk_pins = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_strobes", 32'({ce0, oe0, wen0}), 32'h7);
      check("midrst_ack_busy", 32'({ack0, busy0}), 32'd0);
      check("midrst_rp", 32'(rp0), 32'd0);
      check("midrst_rdata", rdata0, 32'd0);
      sb_q.delete();
      free_cyc = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (LAT0 + 2) cycle_req(1'b0, 23'h000300);
      chk_pins = 1'b1;
      cycle_req(1'b1, 23'h000020);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
